ascii_decimal_stream_parser: RTL and testbench
==============================================

# ascii_decimal_stream_parser

Sequential, parametrised ASCII-decimal-to-binary converter. It accepts a byte stream (one ASCII character per handshake, most-significant digit first, e.g. from the UART receive path) and accumulates `value = value*10 + digit` until a delimiter byte arrives. It then presents one binary result with digit count and error/overflow status on a valid/ready output. Unlike a fixed 6-character parallel decoder, it handles variable-length fields of up to `MAX_DIGITS`, flags malformed input and overflow, and applies back-pressure.

## Interface
- `WIDTH`, 32: result width in bits, ≥ 8.
- `MAX_DIGITS`, 6: maximum accepted digits per field, 1..10.
- `DELIM`, 8'h0A: field terminator byte.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  parser can accept a byte.
- `in_data`  in  8  ASCII byte.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_number`  out  WIDTH  converted value.
- `out_digits`  out  $clog2(MAX_DIGITS+1)  digits accepted in field.
- `out_error`  out  1  field contained an illegal byte or was empty.
- `out_overflow`  out  1  digit count or value exceeded limits.

## Operation
- Byte accepted when `in_valid && in_ready`. Classes: digit (8'h30..8'h39), `DELIM`, minus (8'h2D, only with the sign feature), other.
- States:
  - IDLE: no bytes yet in the field. Digit → ACCUM. `DELIM` → HOLD with error=1, number 0. Other → DISCARD with error=1.
  - ACCUM: digit → accumulate; `DELIM` → HOLD; other → DISCARD with error=1.
  - DISCARD: swallow bytes until `DELIM`, then → HOLD. Output number 0, error=1.
  - HOLD: `in_ready`=0, `out_valid`=1. On `out_valid && out_ready` → IDLE; accumulator, count and flags clear.
- Arithmetic:
  - `acc_next = acc*10 + digit`, computed at WIDTH+4 bits.
  - Nonzero bits above the limit, or a digit arriving when count == `MAX_DIGITS`, set overflow. The accumulator then saturates to the limit and further digits are counted up to `MAX_DIGITS` only.
  - Unsigned limit: 2^WIDTH−1.
- Overflow and error together: error takes precedence (number 0); both flags are reported.
- `out_number`, `out_digits` and flags are registered and stable throughout HOLD.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_number`=0, `out_digits`=0, `out_error`=0, `out_overflow`=0; state IDLE.
- Throughput: one byte per cycle in IDLE/ACCUM/DISCARD.
- Latency: `DELIM` accepted in cycle n → `out_valid`=1 in cycle n+1.
- Back-pressure:
  - `in_ready` is a registered function of state only, with no combinational path from `out_ready`.
  - Output handshake in cycle m → `in_ready`=1 in cycle m+1. Minimum field period is digits+2 cycles.
- `in_valid` low: state holds; gaps between digits are allowed.
- `reset` asserted mid-field or during HOLD: field discarded, reset values next cycle, no output emitted.

## Configuration
- `ASCII_PARSER_SIGN_EN`
  - Defined: 8'h2D is accepted only as the first byte of a field (IDLE → ACCUM with neg=1, count stays 0).
  - Result is two's complement. Limit magnitude is 2^(WIDTH−1)−1 positive and 2^(WIDTH−1) negative; saturation goes to those bounds.
  - A field of only "-" then `DELIM` → error.
  - Minus anywhere else → DISCARD/error.
  - Undefined: 8'h2D is an ordinary illegal byte, and results are unsigned.

## Structure
- Package `ascii_num_pkg`:
  - constants `ASCII_ZERO`=8'h30, `ASCII_NINE`=8'h39, `ASCII_MINUS`=8'h2D;
  - state enum {IDLE, ACCUM, DISCARD, HOLD};
  - byte-class enum {DIGIT, DELIM_C, MINUS_C, OTHER}.
- Sub-module `ascii_byte_classify`: combinational; inputs byte and `DELIM`, outputs class and 4-bit digit value.
- Top holds the FSM, the multiply-add/saturation datapath and the output registers.

## Test plan
- Defaults; stream "123456\n", `out_ready`=1 → `out_number`=123456, `out_digits`=6, error=0, overflow=0; `out_valid` one cycle after '\n'.
- Stream "1234567\n" → overflow=1, `out_number`=32'hFFFFFFFF, `out_digits`=6; "42\n" next → 42, flags clear.
- Stream "12a34\n" → error=1, `out_number`=0; "\n" alone → error=1, `out_digits`=0.
- `out_ready`=0 for 5 cycles after "7\n" → `in_ready`=0 and outputs stable; release → handshake, `in_ready`=1 next cycle.
- `ASCII_PARSER_SIGN_EN`, WIDTH=16, MAX_DIGITS=5: "-32768\n" → 16'h8000; "-32769\n" → overflow, 16'h8000; "5-\n" → error.
- Assert `reset` after "98" of "987\n" → no output; following "3\n" → 3.

Source files
------------

// File: rtl/ascii_num_pkg.sv
// ascii_num_pkg: shared constants, FSM states and byte classes for the ASCII decimal parser.
package ascii_num_pkg;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD, HOLD} state_t;
    typedef enum logic [1:0] {DIGIT, DELIM_C, MINUS_C, OTHER} byte_class_t;
endpackage

// File: rtl/ascii_byte_classify.sv
// ascii_byte_classify: combinational byte classifier with digit value extraction.
module ascii_byte_classify
    import ascii_num_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [7:0]  delim,
    output byte_class_t cls,
    output logic [3:0]  digit
);
    always_comb begin
        digit = 4'(data - ASCII_ZERO);
        cls   = data == delim ? DELIM_C :
                (data >= ASCII_ZERO && data <= ASCII_NINE) ? DIGIT :
                data == ASCII_MINUS ? MINUS_C : OTHER;
    end
endmodule

// File: rtl/ascii_decimal_stream_parser.sv
// ascii_decimal_stream_parser: streams ASCII decimal fields into saturating binary results.
// Define ASCII_PARSER_SIGN_EN to accept a leading '-' and produce two's complement results.
module ascii_decimal_stream_parser
    import ascii_num_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         MAX_DIGITS = 6,
    parameter logic [7:0] DELIM      = 8'h0A
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [7:0]                         in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_number,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    out_digits,
    output logic                               out_error,
    output logic                               out_overflow
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [WIDTH+3:0] ONE  = 1;
    localparam logic [WIDTH+3:0] TEN  = 10;
    localparam logic [WIDTH+3:0] FULL = (ONE << WIDTH) - ONE;
    localparam logic [WIDTH+3:0] HALF = ONE << (WIDTH - 1);
`ifdef ASCII_PARSER_SIGN_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    state_t           state, state_nx;
    byte_class_t      cls;
    logic [3:0]       digit;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             neg, neg_nx, ovf, ovf_nx, err, err_nx;
    logic [WIDTH+3:0] prod, lim;
    logic             full, dig_ovf, take;

    ascii_byte_classify u_classify (
        .data  (in_data),
        .delim (DELIM),
        .cls   (cls),
        .digit (digit)
    );

    assign in_ready  = state != HOLD;
    assign out_valid = state == HOLD;
    assign take      = in_valid && in_ready;
    // Negative fields may reach one further than positive ones in two's complement.
    assign lim       = !SIGN_EN ? FULL : neg ? HALF : HALF - ONE;
    assign prod      = {4'b0, acc} * TEN + {{WIDTH{1'b0}}, digit};
    assign full      = cnt == CW'(MAX_DIGITS);
    assign dig_ovf   = ovf || full || prod > lim;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        neg_nx   = neg;
        ovf_nx   = ovf;
        err_nx   = err;
        case (state)
            IDLE, ACCUM: if (take) begin
                if (cls == DIGIT) begin
                    state_nx = ACCUM;
                    acc_nx   = dig_ovf ? lim[WIDTH-1:0] : prod[WIDTH-1:0];
                    cnt_nx   = full ? cnt : cnt + CW'(1);
                    ovf_nx   = dig_ovf;
                end else if (cls == DELIM_C) begin
                    state_nx = HOLD;
                    err_nx   = cnt == '0;
                end else if (SIGN_EN && cls == MINUS_C && state == IDLE) begin
                    state_nx = ACCUM;
                    neg_nx   = 1'b1;
                end else begin
                    state_nx = DISCARD;
                    err_nx   = 1'b1;
                end
            end
            DISCARD: state_nx = take && cls == DELIM_C ? HOLD : DISCARD;
            HOLD: if (out_ready) begin
                state_nx = IDLE;
                acc_nx   = '0;
                cnt_nx   = '0;
                neg_nx   = 1'b0;
                ovf_nx   = 1'b0;
                err_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_nx;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc          <= '0;
            cnt          <= '0;
            neg          <= 1'b0;
            ovf          <= 1'b0;
            err          <= 1'b0;
            out_number   <= '0;
            out_digits   <= '0;
            out_error    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            neg <= neg_nx;
            ovf <= ovf_nx;
            err <= err_nx;
            if (state != HOLD && state_nx == HOLD) begin
                out_number   <= err_nx ? '0 : neg_nx ? '0 - acc_nx : acc_nx;
                out_digits   <= cnt_nx;
                out_error    <= err_nx;
                out_overflow <= ovf_nx;
            end else if (state == HOLD && state_nx == IDLE) begin
                out_number   <= '0;
                out_digits   <= '0;
                out_error    <= 1'b0;
                out_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ascii_decimal_stream_parser.sv
// tb_ascii_decimal_stream_parser: directed and random fields against a string-level reference model.
module tb_ascii_decimal_stream_parser;
`ifdef ASCII_PARSER_SIGN_EN
    localparam bit SIGN = 1'b1;
    localparam int W    = 16;
    localparam int MD   = 5;
`else
    localparam bit SIGN = 1'b0;
    localparam int W    = 32;
    localparam int MD   = 6;
`endif
    localparam int         DW = $clog2(MD + 1);
    localparam logic [7:0] NL = 8'h0A;
    typedef logic [7:0] u8;

    logic          clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, out_valid, out_error, out_overflow;
    logic [W-1:0]  out_number;
    logic [DW-1:0] out_digits;
    int total = 0, bad = 0;

    ascii_decimal_stream_parser #(.WIDTH(W), .MAX_DIGITS(MD), .DELIM(NL)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_number   (out_number),
        .out_digits   (out_digits),
        .out_error    (out_error),
        .out_overflow (out_overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Whole-field interpretation: sign, digits, then range and length limits applied once.
    function automatic void model(input u8 q[$], output logic [W-1:0] num, output int dig,
                                  output bit err, output bit ovf);
        longint mag = 0, lim;
        bit neg = 0;
        dig = 0; err = 0; ovf = 0;
        for (int i = 0; i < q.size() && !err; i++) begin
            if (q[i] >= 8'h30 && q[i] <= 8'h39) begin
                mag = mag * 10 + longint'(q[i] - 8'h30);
                if (dig == MD) ovf = 1; else dig++;
            end else if (SIGN && i == 0 && q[i] == 8'h2D) neg = 1;
            else err = 1;
        end
        lim = !SIGN ? (longint'(1) << W) - 1 : neg ? (longint'(1) << (W - 1)) : (longint'(1) << (W - 1)) - 1;
        if (mag > lim) ovf = 1;
        if (dig == 0) err = 1;
        num = err ? '0 : W'(neg ? -(ovf ? lim : mag) : (ovf ? lim : mag));
    endfunction

    task automatic send_byte(input u8 c, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
        end
        chk("in_ready_before_byte", in_ready, 1);
        in_valid = 1'b1;
        in_data  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drive_check(input u8 q[$], input logic [W-1:0] en, input int ed, input bit ee,
                               input bit eo, input bit gaps, input int stall);
        foreach (q[i]) send_byte(q[i], gaps);
        chk("midfield_out_valid", out_valid, 0);
        send_byte(NL, gaps);
        chk("latency_out_valid", out_valid, 1);
        chk("number", out_number, en);
        chk("digits", out_digits, ed);
        chk("error", out_error, ee);
        chk("overflow", out_overflow, eo);
        repeat (stall) begin
            in_valid = 1'($urandom);
            in_data  = 8'h35;
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_number", out_number, en);
            chk("stall_digits", out_digits, ed);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
    endtask

    task automatic run_exp(input string s, input logic [W-1:0] en, input int ed, input bit ee,
                           input bit eo, input int stall);
        u8 q[$];
        for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
        drive_check(q, en, ed, ee, eo, 1'b0, stall);
    endtask

    task automatic run_rand();
        u8 q[$];
        logic [W-1:0] en;
        int ed, len, r;
        bit ee, eo;
        len = $urandom_range(0, 9);
        if (SIGN && $urandom_range(0, 3) == 0) q.push_back(8'h2D);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 99);
            q.push_back(r < 80 ? u8'(8'h30 + $urandom_range(0, 9)) : r < 88 ? 8'h2D : u8'(8'h41 + $urandom_range(0, 25)));
        end
        model(q, en, ed, ee, eo);
        drive_check(q, en, ed, ee, eo, 1'b1, $urandom_range(0, 2));
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_number", out_number, 0);
        chk("reset_digits", out_digits, 0);
        chk("reset_error", out_error, 0);
        chk("reset_overflow", out_overflow, 0);
        reset = 1'b0;
        tick();
`ifdef ASCII_PARSER_SIGN_EN
        run_exp("-32768", 16'h8000, 5, 0, 0, 0);
        run_exp("-32769", 16'h8000, 5, 0, 1, 1);
        run_exp("5-", 16'h0000, 1, 1, 0, 0);
        run_exp("32767", 16'h7FFF, 5, 0, 0, 0);
        run_exp("32768", 16'h7FFF, 5, 0, 1, 0);
        run_exp("-", 16'h0000, 0, 1, 0, 0);
        run_exp("-42", 16'hFFD6, 2, 0, 0, 0);
        run_exp("123456", 16'h7FFF, 5, 0, 1, 0);
`else
        run_exp("123456", 32'd123456, 6, 0, 0, 0);
        run_exp("1234567", 32'hFFFFFFFF, 6, 0, 1, 0);
        run_exp("42", 32'd42, 2, 0, 0, 0);
        run_exp("12a34", 32'd0, 2, 1, 0, 0);
        run_exp("-5", 32'd0, 0, 1, 0, 0);
`endif
        run_exp("", '0, 0, 1, 0, 0);
        run_exp("7", W'(7), 1, 0, 0, 5);
        send_byte(8'h39, 1'b0);
        send_byte(8'h38, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_number", out_number, 0);
        chk("midreset_digits", out_digits, 0);
        tick();
        chk("midreset_no_output", out_valid, 0);
        run_exp("3", W'(3), 1, 0, 0, 0);
        send_byte(8'h35, 1'b0);
        send_byte(NL, 1'b0);
        chk("hold_before_reset", out_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("holdreset_out_valid", out_valid, 0);
        chk("holdreset_error", out_error, 0);
        run_exp("8", W'(8), 1, 0, 0, 1);
        for (int f = 0; f < 150; f++) run_rand();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
